mgmt_qspi_bus_bridge: RTL and testbench



---
 rtl/mgmt_qspi_bus_bridge.sv | 190 +++++++++++++++++++
 tb/tb_mgmt_qspi_bus_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mgmt_qspi_bus_bridge.sv
// QSPI byte-stream to management register bus bridge: 16-bit header (R/W + 15-bit address), then auto-incrementing data.
// Optional read timeout enabled by defining MGMT_BRIDGE_RD_TIMEOUT_EN.
module mgmt_qspi_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  TIMEOUT_DATA   = 8'hff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        rx_end,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_underrun,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic        rd_valid,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_timeout
);

    localparam int unsigned ADDR_W = 15;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WRITE, RD_WAIT, RD_HOLD
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic                flag, flag_nxt;
    logic                tx_valid_nxt, tx_underrun_nxt, rd_en_nxt, wr_en_nxt;
    logic [7:0]          tx_data_nxt, wr_data_nxt;
    logic [15:0]         rd_addr_nxt, wr_addr_nxt;

`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                timeout_q, timeout_nxt;
    // Set when a read timed out; the first rd_valid afterwards belongs to that read and is dropped.
    logic                stale, stale_nxt;
`else
    logic [39:0]         unused_cfg;
    assign unused_cfg = {TIMEOUT_DATA, 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            flag        <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            tx_underrun <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
            cnt         <= '0;
            timeout_q   <= 1'b0;
            stale       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            flag        <= flag_nxt;
            tx_valid    <= tx_valid_nxt;
            tx_data     <= tx_data_nxt;
            tx_underrun <= tx_underrun_nxt;
            rd_en       <= rd_en_nxt;
            rd_addr     <= rd_addr_nxt;
            wr_en       <= wr_en_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
            cnt         <= cnt_nxt;
            timeout_q   <= timeout_nxt;
            stale       <= stale_nxt;
`endif
        end
    end

`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
    assign rd_timeout = timeout_q;
`else
    assign rd_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        flag_nxt        = flag;
        tx_valid_nxt    = tx_valid;
        tx_data_nxt     = tx_data;
        tx_underrun_nxt = 1'b0;
        rd_en_nxt       = 1'b0;
        rd_addr_nxt     = rd_addr;
        wr_en_nxt       = 1'b0;
        wr_addr_nxt     = wr_addr;
        wr_data_nxt     = wr_data;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
        cnt_nxt         = cnt;
        timeout_nxt     = timeout_q;
        stale_nxt       = stale;
        if (rd_valid && stale && !rx_start) begin
            stale_nxt = 1'b0;
        end
`endif
        if (rx_start) begin
            state_nxt    = ADDR_HI;
            tx_valid_nxt = 1'b0;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
            timeout_nxt  = 1'b0;
            stale_nxt    = 1'b0;
`endif
        end else if (rx_end) begin
            state_nxt    = IDLE;
            tx_valid_nxt = 1'b0;
        end else begin
            case (state)
                ADDR_HI: if (rx_valid) begin
                    flag_nxt        = rx_data[7];
                    addr_nxt[14:8]  = rx_data[6:0];
                    state_nxt       = ADDR_LO;
                end
                ADDR_LO: if (rx_valid) begin
                    addr_nxt[7:0] = rx_data;
                    if (flag) begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = {1'b0, addr[14:8], rx_data};
                        state_nxt   = RD_WAIT;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
                        cnt_nxt     = '0;
`endif
                    end else begin
                        state_nxt   = WRITE;
                    end
                end
                WRITE: if (rx_valid) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = {1'b0, addr};
                    wr_data_nxt = rx_data;
                    addr_nxt    = addr + ADDR_W'(1);
                end
                RD_WAIT: begin
                    tx_underrun_nxt = tx_ready;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
                    if (rd_valid && !stale) begin
`else
                    if (rd_valid) begin
`endif
                        tx_data_nxt  = rd_data;
                        tx_valid_nxt = 1'b1;
                        addr_nxt     = addr + ADDR_W'(1);
                        state_nxt    = RD_HOLD;
                    end
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_data_nxt  = TIMEOUT_DATA;
                        tx_valid_nxt = 1'b1;
                        timeout_nxt  = 1'b1;
                        stale_nxt    = 1'b1;
                        addr_nxt     = addr + ADDR_W'(1);
                        state_nxt    = RD_HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
`endif
                end
                RD_HOLD: if (tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    rd_en_nxt    = 1'b1;
                    rd_addr_nxt  = {1'b0, addr};
                    state_nxt    = RD_WAIT;
`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
                    cnt_nxt      = '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_qspi_bus_bridge.sv
// Directed self-checking bench for mgmt_qspi_bus_bridge (timeout steps active when MGMT_BRIDGE_RD_TIMEOUT_EN is defined).
module tb_mgmt_qspi_bus_bridge;

    logic        clk, rst_n;
    logic        rx_start, rx_end, rx_valid, tx_ready, rd_valid;
    logic [7:0]  rx_data, rd_data;
    logic        tx_valid, tx_underrun, rd_en, wr_en, rd_timeout;
    logic [7:0]  tx_data, wr_data;
    logic [15:0] rd_addr, wr_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_wr    = 0;
    int n_both  = 0;

    mgmt_qspi_bus_bridge #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(8'hff)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_start(rx_start), .rx_end(rx_end), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_underrun(tx_underrun),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_timeout(rd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_en) n_rd++;
        if (wr_en) n_wr++;
        if (rd_en && wr_en) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_t();
        rx_start = 1'b1; tick(); rx_start = 1'b0;
    endtask

    task automatic end_t();
        rx_end = 1'b1; tick(); rx_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
    endtask

    task automatic ready();
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    endtask

    task automatic rdata(input logic [7:0] d);
        rd_valid = 1'b1; rd_data = d; tick(); rd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_start = 1'b0; rx_end = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tx_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        tick(); tick();
        chk("rst_tx_valid", 16'(tx_valid), 16'h0);
        chk("rst_tx_data", 16'(tx_data), 16'h0);
        chk("rst_rd_en", 16'(rd_en), 16'h0);
        chk("rst_wr_en", 16'(wr_en), 16'h0);
        chk("rst_addrs", rd_addr | wr_addr, 16'h0);
        chk("rst_misc", 16'({tx_underrun, rd_timeout, wr_data}), 16'h0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores bytes and tx_ready
        send(8'h80); send(8'h00); ready();
        chk("idle_ignore", 16'({rd_en, wr_en, tx_underrun}), 16'h0);

        // Write 0x0048: AA BB CC back-to-back
        start_t();
        send(8'h00); send(8'h48);
        chk("wr_hdr_no_wr", 16'(wr_en), 16'h0);
        send(8'hAA);
        chk("wr0_en", 16'(wr_en), 16'h1);
        chk("wr0_addr", wr_addr, 16'h0048);
        chk("wr0_data", 16'(wr_data), 16'h00AA);
        send(8'hBB);
        chk("wr1", {wr_addr[7:0], wr_data}, 16'h49BB);
        chk("wr1_en", 16'(wr_en), 16'h1);
        send(8'hCC);
        chk("wr2", {wr_addr[7:0], wr_data}, 16'h4ACC);
        tick();
        chk("wr_idle_after", 16'(wr_en), 16'h0);
        chk("wr_no_rd", 16'(n_rd), 16'h0);
        end_t();

        // Read at 0x0000: 0x12 then 0x34
        start_t();
        send(8'h80); send(8'h00);
        chk("rd0_en", 16'(rd_en), 16'h1);
        chk("rd0_addr", rd_addr, 16'h0000);
        send(8'hEE);
        chk("rd_dummy_ignored", 16'({rd_en, wr_en}), 16'h0);
        tick();
        rdata(8'h12);
        chk("rd0_tx", {7'h0, tx_valid, tx_data}, 16'h0112);
        tick(); tick();
        chk("rd_no_prefetch", 16'(n_rd), 16'h1);
        ready();
        chk("rd1_en", 16'(rd_en), 16'h1);
        chk("rd1_addr", rd_addr, 16'h0001);
        chk("rd1_tx_cleared", 16'(tx_valid), 16'h0);
        tick(); tick();
        rdata(8'h34);
        chk("rd1_tx", {7'h0, tx_valid, tx_data}, 16'h0134);
        end_t();
        chk("rd_end_txv", 16'(tx_valid), 16'h0);
        ready(); tick(); tick();
        chk("rd_end_no_rd", 16'(n_rd), 16'h2);

        // Address wrap 0x7fff -> 0x0000
        start_t();
        send(8'h7f); send(8'hff); send(8'h11);
        chk("wrap0", wr_addr, 16'h7fff);
        send(8'h22);
        chk("wrap1", wr_addr, 16'h0000);
        chk("wrap1_data", 16'(wr_data), 16'h0022);
        end_t();

        // Abort during RD_WAIT, then a fresh write
        start_t();
        send(8'h80); send(8'h05);
        chk("abort_rd_addr", rd_addr, 16'h0005);
        end_t();
        rdata(8'h55); tick();
        chk("abort_txv", 16'(tx_valid), 16'h0);
        start_t();
        send(8'h00); send(8'h10); send(8'h01);
        chk("abort_wr", {wr_en, wr_addr[6:0], wr_data}, 16'h9001);
        end_t();

        // Underrun in RD_WAIT
        start_t();
        send(8'h80); send(8'h20);
        ready();
        chk("urun_pulse", 16'({tx_underrun, tx_valid}), 16'h2);
        tick();
        chk("urun_single", 16'(tx_underrun), 16'h0);
        rdata(8'h77);
        chk("urun_tx", {7'h0, tx_valid, tx_data}, 16'h0177);
        ready();
        chk("hold_ready", {tx_underrun, rd_en, rd_addr[13:0]}, 16'h4021);
        end_t();

`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
        start_t();
        send(8'h80); send(8'h40);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", 16'(tx_valid), 16'h0);
        tick();
        chk("to_tx", {6'h0, rd_timeout, tx_valid, tx_data}, 16'h03FF);
        rdata(8'h99);
        chk("to_late_ignored", 16'(tx_data), 16'h00FF);
        ready();
        chk("to_next_rd", rd_addr, 16'h0041);
        rdata(8'h66);
        chk("to_next_tx", {6'h0, rd_timeout, tx_valid, tx_data}, 16'h0366);
        start_t();
        chk("to_cleared", 16'(rd_timeout), 16'h0);
        end_t();
        chk("rd_total", 16'(n_rd), 16'h0007);
`else
        chk("no_timeout", 16'(rd_timeout), 16'h0);
        chk("rd_total", 16'(n_rd), 16'h0005);
`endif
        chk("wr_total", 16'(n_wr), 16'h0006);
        chk("rd_wr_exclusive", 16'(n_both), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
